// File: rtl/ir_pkg.sv
// Shared types and constants for the multi-byte instruction register and its
// sequencer.
package ir_pkg;

  typedef enum logic [1:0] {
    S_OPC  = 2'd0,
    S_OPND = 2'd1,
    S_HOLD = 2'd2
  } ir_state_t;

  // Two bits per opcode, opcode 0 in the low bits: 0x8-0xB -> 1, 0xC-0xD -> 2.
  localparam logic [31:0] OPLEN_DEFAULT = 32'h0A55_0000;

  function automatic int oplen_sat(input logic [1:0] raw, input int max_ops);
    return (int'(raw) > max_ops) ? max_ops : int'(raw);
  endfunction

endpackage

// File: rtl/ir_multi_if.sv
// Bus-side handshake and decoded-instruction bundle of ir_multi.
interface ir_multi_if #(
  parameter int BUS_W        = 8,
  parameter int OPC_W        = 4,
  parameter int MAX_OPERANDS = 2
);
  localparam int CNT_W = $clog2(MAX_OPERANDS + 1);

  logic                          load;
  logic [BUS_W-1:0]              bus;
  logic                          consume;
  logic [OPC_W-1:0]              instr_out;
  logic [BUS_W-OPC_W-1:0]        addr_out;
  logic [MAX_OPERANDS*BUS_W-1:0] operand_out;
  logic [CNT_W-1:0]              operand_cnt;
  logic                          instr_valid;
  logic                          fetch_req;
  logic                          overrun;

  modport master (
    output load, bus, consume,
    input  instr_out, addr_out, operand_out, operand_cnt,
           instr_valid, fetch_req, overrun
  );

  modport slave (
    input  load, bus, consume,
    output instr_out, addr_out, operand_out, operand_cnt,
           instr_valid, fetch_req, overrun
  );
endinterface

// File: rtl/ir_len_decode.sv
// Opcode -> operand count, saturated to MAX_OPERANDS. Purely combinational.
module ir_len_decode
  import ir_pkg::*;
#(
  parameter int                      OPC_W        = 4,
  parameter int                      MAX_OPERANDS = 2,
  parameter logic [(2**OPC_W)*2-1:0] OPLEN_MAP    = OPLEN_DEFAULT,
  localparam int                     CNT_W        = $clog2(MAX_OPERANDS + 1)
) (
  input  logic [OPC_W-1:0] opcode,
  output logic [CNT_W-1:0] need
);
  logic [1:0] raw;

  assign raw  = OPLEN_MAP[{opcode, 1'b0} +: 2];
  assign need = CNT_W'(oplen_sat(raw, MAX_OPERANDS));
endmodule

// File: rtl/ir_multi.sv
// Multi-byte instruction register: opcode byte plus up to MAX_OPERANDS operands.
// Optional one-byte prefetch skid buffer under `define IR_PREFETCH_EN.
module ir_multi
  import ir_pkg::*;
#(
  parameter int                      BUS_W        = 8,
  parameter int                      OPC_W        = 4,
  parameter int                      MAX_OPERANDS = 2,
  parameter logic [(2**OPC_W)*2-1:0] OPLEN_MAP    = OPLEN_DEFAULT
) (
  input logic        clk,
  input logic        rst,
  ir_multi_if.slave  bus_if
);
  localparam int CNT_W = $clog2(MAX_OPERANDS + 1);

  ir_state_t                             state, state_d;
  logic [BUS_W-1:0]                      opc_byte, opc_src;
  logic [MAX_OPERANDS-1:0][BUS_W-1:0]    operands;
  logic [CNT_W-1:0]                      cnt, idx, need;
  logic                                  overrun;
  logic                                  cap_opc, cap_opnd, set_ovr;

`ifdef IR_PREFETCH_EN
  logic [BUS_W-1:0] skid;
  logic             skid_vld, skid_ld, skid_clr;

  // A buffered byte always precedes anything currently on the bus.
  assign opc_src = skid_vld ? skid : bus_if.bus;
`else
  assign opc_src = bus_if.bus;
`endif

  ir_len_decode #(.OPC_W(OPC_W), .MAX_OPERANDS(MAX_OPERANDS), .OPLEN_MAP(OPLEN_MAP))
    u_len (.opcode(opc_src[BUS_W-1 -: OPC_W]), .need(need));

  always_comb begin
    state_d  = state;
    cap_opc  = 1'b0;
    cap_opnd = 1'b0;
    set_ovr  = 1'b0;
`ifdef IR_PREFETCH_EN
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
`endif
    unique case (state)
      S_OPC: begin
`ifdef IR_PREFETCH_EN
        // A byte buffered during a consume with an empty skid is taken here.
        if (skid_vld) begin
          cap_opc  = 1'b1;
          skid_clr = 1'b1;
          skid_ld  = bus_if.load;
        end else
`endif
        if (bus_if.load) cap_opc = 1'b1;
        if (cap_opc) state_d = (need == '0) ? S_HOLD : S_OPND;
      end
      S_OPND: begin
        if (bus_if.load) begin
          cap_opnd = 1'b1;
          if ((idx + CNT_W'(1)) == cnt) state_d = S_HOLD;
        end
      end
      S_HOLD: begin
`ifdef IR_PREFETCH_EN
        if (bus_if.consume) begin
          if (skid_vld) begin
            cap_opc  = 1'b1;
            skid_clr = 1'b1;
            state_d  = (need == '0) ? S_HOLD : S_OPND;
          end else begin
            state_d = S_OPC;
          end
        end
        if (bus_if.load) begin
          if (!skid_vld || bus_if.consume) skid_ld = 1'b1;
          else                             set_ovr = 1'b1;
        end
`else
        if (bus_if.consume) state_d = S_OPC;
        if (bus_if.load)    set_ovr = 1'b1;
`endif
      end
      default: state_d = S_OPC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_OPC;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc_byte <= '0;
      operands <= '0;
      cnt      <= '0;
      idx      <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= overrun | set_ovr;
      if (cap_opc) begin
        opc_byte <= opc_src;
        operands <= '0;
        cnt      <= need;
        idx      <= '0;
      end
      if (cap_opnd) begin
        for (int k = 0; k < MAX_OPERANDS; k++)
          if (idx == CNT_W'(k)) operands[k] <= bus_if.bus;
        idx <= idx + CNT_W'(1);
      end
    end
  end

`ifdef IR_PREFETCH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid     <= '0;
      skid_vld <= 1'b0;
    end else if (skid_ld) begin
      skid     <= bus_if.bus;
      skid_vld <= 1'b1;
    end else if (skid_clr) begin
      skid_vld <= 1'b0;
    end
  end

  assign bus_if.fetch_req = !(state == S_HOLD && skid_vld);
`else
  assign bus_if.fetch_req = (state != S_HOLD);
`endif

  assign bus_if.instr_out   = opc_byte[BUS_W-1 -: OPC_W];
  assign bus_if.addr_out    = opc_byte[BUS_W-OPC_W-1:0];
  assign bus_if.operand_out = operands;
  assign bus_if.operand_cnt = cnt;
  assign bus_if.instr_valid = (state == S_HOLD);
  assign bus_if.overrun     = overrun;
endmodule

// File: tb/tb_ir_multi.sv
// Directed-vector bench for ir_multi; expected values are hand-computed.
module tb_ir_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  ir_multi_if ifc ();
  ir_multi dut (.clk(clk), .rst(rst), .bus_if(ifc));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [7:0] b, input logic cons);
    ifc.load    = ld;
    ifc.bus     = b;
    ifc.consume = cons;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(ifc.instr_valid), 0);
    chk({tag, ".freq"},  32'(ifc.fetch_req), 1);
    chk({tag, ".instr"}, 32'(ifc.instr_out), 0);
    chk({tag, ".addr"},  32'(ifc.addr_out), 0);
    chk({tag, ".opnd"},  32'(ifc.operand_out), 0);
    chk({tag, ".cnt"},   32'(ifc.operand_cnt), 0);
    chk({tag, ".ovr"},   32'(ifc.overrun), 0);
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk_zero("rst");
    rst = 1'b0;

    // Reset in the middle of operand collection.
    drive(1'b1, 8'hC3, 1'b0); tick();
    drive(1'b1, 8'h5A, 1'b0); tick();
    chk("mid.valid", 32'(ifc.instr_valid), 0);
    drive(1'b0, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1 chk_zero("arst");
    rst = 1'b0;

    drive(1'b1, 8'h21, 1'b0); tick();
    chk("h21.valid", 32'(ifc.instr_valid), 1);
    chk("h21.instr", 32'(ifc.instr_out), 32'h2);
    chk("h21.addr",  32'(ifc.addr_out), 32'h1);
    chk("h21.cnt",   32'(ifc.operand_cnt), 0);
    chk("h21.opnd",  32'(ifc.operand_out), 0);
    chk("h21.freq",  32'(ifc.fetch_req), 0);

    // Byte arrives while held, no consume.
    drive(1'b1, 8'h99, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("hold.instr", 32'(ifc.instr_out), 32'h2);
    chk("hold.valid", 32'(ifc.instr_valid), 1);
`ifdef IR_PREFETCH_EN
    chk("hold.ovr",  32'(ifc.overrun), 0);
    chk("hold.freq", 32'(ifc.fetch_req), 0);
    drive(1'b0, 8'h00, 1'b1); tick();
    chk("pf.instr", 32'(ifc.instr_out), 32'h9);
    chk("pf.cnt",   32'(ifc.operand_cnt), 1);
    chk("pf.valid", 32'(ifc.instr_valid), 0);
    drive(1'b1, 8'h55, 1'b0); tick();
    chk("pf.valid2", 32'(ifc.instr_valid), 1);
    chk("pf.opnd",   32'(ifc.operand_out), 32'h0055);
`else
    chk("hold.ovr",  32'(ifc.overrun), 1);
    chk("hold.addr", 32'(ifc.addr_out), 32'h1);
    drive(1'b0, 8'h00, 1'b1); tick();
    chk("cons.valid", 32'(ifc.instr_valid), 0);
    chk("cons.freq",  32'(ifc.fetch_req), 1);
`endif
    drive(1'b0, 8'h00, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;

    // Back-to-back two-operand instruction.
    drive(1'b1, 8'hC0, 1'b0); tick();
    chk("c0.v1", 32'(ifc.instr_valid), 0);
    drive(1'b1, 8'h34, 1'b0); tick();
    chk("c0.v2", 32'(ifc.instr_valid), 0);
    drive(1'b1, 8'h12, 1'b0); tick();
    chk("c0.v3",    32'(ifc.instr_valid), 1);
    chk("c0.opnd",  32'(ifc.operand_out), 32'h1234);
    chk("c0.cnt",   32'(ifc.operand_cnt), 2);
    chk("c0.instr", 32'(ifc.instr_out), 32'hC);
    chk("c0.addr",  32'(ifc.addr_out), 32'h0);
    drive(1'b0, 8'h00, 1'b1); tick();
    chk("c0.rel", 32'(ifc.instr_valid), 0);

    // One-operand instruction with a bubble and a stray consume in S_OPND.
    drive(1'b1, 8'h80, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0); tick();
    chk("b80.bub", 32'(ifc.instr_valid), 0);
    drive(1'b0, 8'h00, 1'b1); tick();
    chk("b80.cons", 32'(ifc.instr_valid), 0);
    chk("b80.freq", 32'(ifc.fetch_req), 1);
    drive(1'b1, 8'h7F, 1'b0); tick();
    chk("b80.valid", 32'(ifc.instr_valid), 1);
    chk("b80.opnd",  32'(ifc.operand_out), 32'h007F);
    chk("b80.cnt",   32'(ifc.operand_cnt), 1);
    chk("b80.instr", 32'(ifc.instr_out), 32'h8);

    // Consume in S_OPC is ignored.
    drive(1'b0, 8'h00, 1'b1); tick();
    tick();
    chk("opc.cons", 32'(ifc.instr_valid), 0);
    drive(1'b1, 8'h21, 1'b0); tick();
    chk("opc.h21", 32'(ifc.instr_valid), 1);
    chk("opc.opnd", 32'(ifc.operand_out), 0);

    // Consume and load together in S_HOLD.
    drive(1'b1, 8'h10, 1'b1); tick();
    drive(1'b0, 8'h00, 1'b0);
    chk("cl.valid", 32'(ifc.instr_valid), 0);
`ifdef IR_PREFETCH_EN
    chk("cl.ovr", 32'(ifc.overrun), 0);
    tick();
    chk("cl.instr", 32'(ifc.instr_out), 32'h1);
    chk("cl.valid2", 32'(ifc.instr_valid), 1);
`else
    chk("cl.ovr",   32'(ifc.overrun), 1);
    chk("cl.instr", 32'(ifc.instr_out), 32'h2);
    drive(1'b1, 8'h30, 1'b0); tick();
    chk("cl.next",  32'(ifc.instr_out), 32'h3);
    chk("cl.valid2", 32'(ifc.instr_valid), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ir_multi.md
# ir_multi

Multi-byte instruction register for the SAP-2 datapath and the successor to the single-byte SAP-1 IR. Assembles one variable-length instruction (opcode byte plus 0..MAX_OPERANDS operand bytes) from successive bus loads. Holds it stable for the control unit until released with `consume`. Sits between the bus and the controller/sequencer; operand bytes feed the MAR/PC load paths.

## Interface
- `BUS_W`, 8, width of the bus and of each instruction byte.
- `OPC_W`, 4, opcode field width, taken from the top bits of the opcode byte.
- `MAX_OPERANDS`, 2, maximum operand bytes per instruction (≥1).
- `OPLEN_MAP`, `ir_pkg::OPLEN_DEFAULT`, packed 2^OPC_W × 2-bit table giving the operand count per opcode.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `load`  in  1  bus carries an instruction-stream byte this cycle.
- `bus`  in  BUS_W  byte to capture.
- `consume`  in  1  controller releases the current instruction.
- `instr_out`  out  OPC_W  opcode, `opcode_byte[BUS_W-1 -: OPC_W]`.
- `addr_out`  out  BUS_W-OPC_W  short address, the low field of the opcode byte.
- `operand_out`  out  MAX_OPERANDS*BUS_W  operands; byte k sits in `[k*BUS_W +: BUS_W]`.
- `operand_cnt`  out  $clog2(MAX_OPERANDS+1)  operand count of the held instruction.
- `instr_valid`  out  1  complete instruction held.
- `fetch_req`  out  1  block will accept a byte on `load` this cycle.
- `overrun`  out  1  sticky; a byte was lost.

## Operation
- FSM states: `S_OPC` (awaiting opcode), `S_OPND` (collecting operands), `S_HOLD` (instruction complete).
- **S_OPC, `load`=1:**
  - Capture the opcode byte.
  - Zero all operand bytes.
  - Look up `need` = OPLEN_MAP[opcode], saturated to MAX_OPERANDS.
  - Go to `S_HOLD` if `need`==0, otherwise go to `S_OPND` with index=0.
- **S_OPND, `load`=1:**
  - Store the byte at the current index, then increment the index.
  - Go to `S_HOLD` when index+1 == `need`.
- **S_HOLD:**
  - Outputs are frozen.
  - `consume`=1 goes to `S_OPC`.
  - `load`=1 without the prefetch feature: byte is dropped and `overrun` is set.
- `consume` outside `S_HOLD` is ignored.
- `fetch_req` = state != `S_HOLD` (prefetch build: see Configuration).
- `instr_valid` = state == `S_HOLD`.
- `operand_cnt` = `need`. It is registered at opcode capture.
- Reset, asynchronous at any time:
  - State returns to `S_OPC`.
  - Every output register is cleared: `instr_out`, `addr_out`, `operand_out`, `operand_cnt`, and `overrun` are all 0.
  - `instr_valid`=0 and `fetch_req`=1.
  - A partially assembled instruction is discarded.

## Timing
- Capture happens on the rising edge where `load`=1.
- `instr_valid` rises on the edge that captures the last byte. It is visible the cycle after that edge.
- Latency: need+1 load cycles. Back-to-back loads give valid in need+1 cycles.
- `consume` is sampled on an edge; `instr_valid` falls the cycle after.
- Without prefetch, the earliest next opcode capture is the cycle after `consume`.
- `consume` and `load` in the same `S_HOLD` cycle: the byte is handled as an `S_HOLD` load (dropped, or buffered with prefetch), not as an opcode.
- Outputs are register-driven only, with no combinational path from `bus`.

## Configuration
- `IR_PREFETCH_EN` defined:
  - Adds a one-byte skid register plus a skid-valid flag.
  - In `S_HOLD`, a `load` with the skid empty stores the byte into the skid register.
  - A `load` with the skid full sets `overrun`.
  - `fetch_req` = !(`S_HOLD` && skid full).
  - On `consume`, if the skid is full, its byte is processed as the opcode on the same edge, exactly as an `S_OPC` load. The next state is `S_HOLD` or `S_OPND`, and the skid empties.
  - A `load` in the same cycle as that `consume` refills the skid.
  - Reset empties the skid.
- `IR_PREFETCH_EN` undefined: behaviour is exactly as in Operation. No skid logic is present.

## Structure
- `ir_pkg` holds:
  - `OPLEN_DEFAULT`: opcodes 0x8–0xB take 1 operand, 0xC–0xD take 2 operands, all others take 0.
  - The state enum `ir_state_t`.
  - The saturation helper function `oplen_sat`.
- Sub-module `ir_len_decode`: combinational, maps opcode and OPLEN_MAP to a saturated operand count. It is reused by the controller's sequencer.

## Test plan
- Reset mid-`S_OPND`, after opcode 0xC3 and one operand 0x5A -> all outputs 0, `fetch_req`=1, `instr_valid`=0; the next `load` of 0x21 is taken as an opcode.
- Load 0x21 -> next cycle: `instr_valid`=1, `instr_out`=0x2, `addr_out`=0x1, `operand_cnt`=0, `operand_out`=0.
- Loads 0xC0, 0x34, 0x12 back-to-back -> `instr_valid` set 3 cycles later; `operand_out`=0x1234, `operand_cnt`=2.
- Load 0x80 with a bubble cycle, then 0x7F -> `instr_valid` only after 0x7F; `operand_out`=0x007F.
- Held 0x21, then `load` 0x99 without `consume`:
  - Without prefetch: `overrun`=1 and held values are unchanged.
  - With `IR_PREFETCH_EN`: no overrun; on `consume`, 0x99 becomes the opcode and the FSM goes to `S_OPND`.
- `consume` while `S_OPND` or `S_OPC` -> no state change. Then `consume` plus `load` 0x10 in `S_HOLD` -> without prefetch the byte is dropped, `overrun`=1, and the FSM returns to `S_OPC`.
